// File: rtl/mmult_seq_if.sv
// rtl/mmult_seq_if.sv - start/valid operand and result bundle for mmult_seq
interface mmult_seq_if #(
    parameter int N  = 3,
    parameter int DW = 8
);
    localparam int CW = 2 * DW + $clog2(N);

    logic              start;
    logic              signed_mode;
    logic [N*N*DW-1:0] A_mat;
    logic [N*N*DW-1:0] B_mat;
    logic              busy;
    logic              valid;
    logic [N*N*CW-1:0] C_mat;

    modport master (
        output start, signed_mode, A_mat, B_mat,
        input  busy, valid, C_mat
    );

    modport slave (
        input  start, signed_mode, A_mat, B_mat,
        output busy, valid, C_mat
    );
endinterface

// File: rtl/mmult_seq.sv
// rtl/mmult_seq.sv - sequential NxN matrix multiplier, one result row per cycle
module mmult_seq #(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    mmult_seq_if.slave bus
);
    localparam int CW = 2 * DW + $clog2(N);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q;
    logic [N*N*DW-1:0] a_q;
    logic [N*N*DW-1:0] b_q;
    logic              signed_q;
    logic [RW-1:0]     row_q;
    logic [N*N*CW-1:0] res_q;
    logic [N*N*CW-1:0] c_q;
    logic              busy_q;
    logic              valid_q;
    logic [N*CW-1:0]   row_d;
    logic [CW-1:0]     acc;

    // Widening to CW before the multiply keeps the signed and unsigned paths identical.
    function automatic logic [CW-1:0] extend(input logic [DW-1:0] v, input logic sm);
        return sm ? {{(CW-DW){v[DW-1]}}, v} : {{(CW-DW){1'b0}}, v};
    endfunction

    always_comb begin
        row_d = '0;
        acc   = '0;
        for (int j = 0; j < N; j++) begin
            acc = '0;
            for (int k = 0; k < N; k++) begin
                acc = acc + extend(a_q[(N*N-1-(int'(row_q)*N+k))*DW +: DW], signed_q)
                          * extend(b_q[(N*N-1-(k*N+j))*DW +: DW], signed_q);
            end
            row_d[(N-1-j)*CW +: CW] = acc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            row_q    <= '0;
            res_q    <= '0;
            c_q      <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.A_mat;
                        b_q      <= bus.B_mat;
                        signed_q <= bus.signed_mode;
                        row_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    res_q[(N-1-int'(row_q))*N*CW +: N*CW] <= row_d;
                    if (row_q == RW'(N - 1)) begin
                        state_q <= DONE;
                    end else begin
                        row_q <= row_q + RW'(1);
                    end
                end
                DONE: begin
                    // Whole-matrix copy so C_mat never shows a partial result.
                    c_q     <= res_q;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.C_mat = c_q;
endmodule

// File: tb/tb_mmult_seq.sv
// tb/tb_mmult_seq.sv - randomized and directed checks of mmult_seq against a matrix model
module tb_mmult_seq;
    localparam int N   = 3;
    localparam int DW  = 8;
    localparam int CW  = 2 * DW + $clog2(N);
    localparam int AW  = N * N * DW;
    localparam int CWT = N * N * CW;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    logic cmp_en  = 1'b0;

    mmult_seq_if #(.N(N), .DW(DW)) bus ();

    mmult_seq #(.N(N), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [CWT-1:0] act, input logic [CWT-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int elem(input logic [AW-1:0] m, input int i, input int j, input logic sm);
        logic [DW-1:0] e;
        e = m[(N*N-1-(i*N+j))*DW +: DW];
        return sm ? int'($signed(e)) : int'(e);
    endfunction

    function automatic logic [CWT-1:0] model_mul(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                                 input logic sm);
        logic [CWT-1:0] c;
        logic [31:0]    su;
        int             s;
        c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += elem(a, i, k, sm) * elem(b, k, j, sm);
                su = s;
                c[(N*N-1-(i*N+j))*CW +: CW] = su[CW-1:0];
            end
        end
        return c;
    endfunction

    function automatic int c_elem(input logic [CWT-1:0] c, input int i, input int j);
        logic [CW-1:0] f;
        f = c[(N*N-1-(i*N+j))*CW +: CW];
        return int'(f);
    endfunction

    function automatic logic [AW-1:0] put(input logic [AW-1:0] m, input int i, input int j, input int v);
        logic [AW-1:0] r;
        logic [31:0]   vv;
        r  = m;
        vv = v;
        r[(N*N-1-(i*N+j))*DW +: DW] = vv[DW-1:0];
        return r;
    endfunction

    function automatic logic [AW-1:0] fill(input int v);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) r = put(r, i, j, v);
        return r;
    endfunction

    function automatic logic [AW-1:0] rnd_mat();
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) r = put(r, i, j, int'($urandom_range(0, (1 << DW) - 1)));
        return r;
    endfunction

    // Model: an accepted op keeps the unit busy for N+1 edges, then the product appears with valid.
    int             m_left  = 0;
    logic           m_valid = 1'b0;
    logic [CWT-1:0] m_c     = '0;
    logic [CWT-1:0] m_pend  = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left  = 0;
            m_valid = 1'b0;
            m_c     = '0;
        end else begin
            m_valid = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_c     = m_pend;
                end
            end else if (bus.start) begin
                m_pend = model_mul(bus.A_mat, bus.B_mat, bus.signed_mode);
                m_left = N + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", CWT'(bus.busy), CWT'(m_left > 0));
            chk("valid", CWT'(bus.valid), CWT'(m_valid));
            chk("c_mat", bus.C_mat, m_c);
        end
    end

    int vq[$];
    always @(negedge clk) if (bus.valid) vq.push_back(cyc);

    task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic sm);
        @(negedge clk);
        bus.A_mat       = a;
        bus.B_mat       = b;
        bus.signed_mode = sm;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        int n;
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.valid) break;
        end
        if (!bus.valid) chk("valid_timeout", 0, 1);
        lat = cyc - acc_cyc;
    endtask

    task automatic expect_all(input string name, input int v);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) chk(name, CWT'(c_elem(bus.C_mat, i, j)), CWT'(v));
    endtask

    initial begin
        logic [AW-1:0] ident, seq;
        int            lat;
        int            nv;

        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.A_mat       = '0;
        bus.B_mat       = '0;

        chk("model_255", CWT'(c_elem(model_mul(fill(255), fill(255), 1'b0), 1, 2)), CWT'(195075));
        chk("model_s80", CWT'(c_elem(model_mul(fill(8'h80), fill(8'h80), 1'b1), 2, 0)), CWT'(49152));
        chk("model_s7f", CWT'(c_elem(model_mul(fill(8'h80), fill(8'h7f), 1'b1), 0, 1)), CWT'('h34180));

        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        #1;
        chk("reset_busy", CWT'(bus.busy), '0);
        chk("reset_valid", CWT'(bus.valid), '0);
        chk("reset_c", bus.C_mat, '0);
        @(negedge clk);
        reset_n = 1'b1;

        ident = '0;
        seq   = '0;
        for (int i = 0; i < N; i++) begin
            ident = put(ident, i, i, 1);
            for (int j = 0; j < N; j++) seq = put(seq, i, j, i * N + j + 1);
        end
        issue(ident, seq, 1'b0);
        wait_valid(lat);
        chk("lat_ident", CWT'(lat), CWT'(N + 1));
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) chk("ident_c", CWT'(c_elem(bus.C_mat, i, j)), CWT'(i * N + j + 1));

        issue(fill(255), fill(255), 1'b0);
        wait_valid(lat);
        expect_all("u255", 195075);

        issue(fill(8'h80), fill(8'h80), 1'b1);
        wait_valid(lat);
        expect_all("s80x80", 49152);
        issue(fill(8'h80), fill(8'h7f), 1'b1);
        wait_valid(lat);
        expect_all("s80x7f", 'h34180);

        // Extra starts and operand churn while busy must not disturb the captured op.
        issue(fill(2), fill(3), 1'b0);
        @(negedge clk); bus.A_mat = fill(7); bus.start = 1'b1;
        @(negedge clk); bus.A_mat = fill(9); bus.signed_mode = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.A_mat = rnd_mat();
        wait_valid(lat);
        chk("lat_busy_start", CWT'(lat), CWT'(N + 1));
        expect_all("busy_start_c", 18);
        nv = 0;
        repeat (N + 4) begin
            @(posedge clk); #1;
            if (bus.valid) nv++;
        end
        chk("no_extra_valid", CWT'(nv), '0);

        vq.delete();
        @(negedge clk);
        bus.start = 1'b1;
        repeat (40) begin
            bus.A_mat       = rnd_mat();
            bus.B_mat       = rnd_mat();
            bus.signed_mode = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (N + 3) @(negedge clk);
        chk("b2b_count", CWT'(vq.size() >= 7), CWT'(1));
        for (int i = 1; i < vq.size(); i++) chk("b2b_gap", CWT'(vq[i] - vq[i-1]), CWT'(N + 2));

        issue(rnd_mat(), rnd_mat(), 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", CWT'(bus.busy), '0);
        chk("rst_valid", CWT'(bus.valid), '0);
        chk("rst_c", bus.C_mat, '0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        nv = 0;
        repeat (N + 4) begin
            @(posedge clk); #1;
            if (bus.valid) nv++;
        end
        chk("rst_no_valid", CWT'(nv), '0);
        issue(fill(1), fill(5), 1'b0);
        wait_valid(lat);
        chk("lat_after_rst", CWT'(lat), CWT'(N + 1));
        expect_all("after_rst_c", 15);

        repeat (2500) begin
            @(negedge clk);
            bus.start       = ($urandom_range(0, 3) == 0);
            bus.signed_mode = 1'($urandom_range(0, 1));
            bus.A_mat       = rnd_mat();
            bus.B_mat       = rnd_mat();
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (N + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
